// File: rtl/ps2_lane_key_decoder_if.sv
// Byte stream from PS2_Controller into the lane key decoder.
// master drives received_data/received_data_en; slave consumes them.
interface ps2_lane_key_decoder_if;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (
    output received_data,
    output received_data_en
  );

  modport slave (
    input received_data,
    input received_data_en
  );
endinterface

// File: rtl/ps2_lane_key_decoder.sv
// PS/2 make/break + E0 parser feeding per-lane held state and
// hit/miss judgement against the tile in the hit row.
module ps2_lane_key_decoder #(
  parameter int NUM_LANES      = 4,
  parameter int COL_W          = 3,
  parameter int CNT_W          = 8,
  parameter bit REQUIRE_EXT    = 1'b1,
  parameter int PREFIX_TIMEOUT = 1_000_000,
  parameter logic [8*NUM_LANES-1:0] LANE_CODES = 32'h7475_726B
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 check_input,
  ps2_lane_key_decoder_if.slave ps2,
  input  logic                 tile_valid,
  input  logic [COL_W-1:0]     tile_column,
  input  logic                 counts_clear,
  output logic [NUM_LANES-1:0] key_held,
  output logic [NUM_LANES-1:0] key_press,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic [1:0]           parser_state
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int TO_W =
    (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [NUM_LANES-1:0] held_q, held_d;
  logic [NUM_LANES-1:0] press_q, press_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [CNT_W-1:0]     hc_q, hc_d;
  logic [CNT_W-1:0]     mc_q, mc_d;

  logic          is_code;
  logic          ext;
  logic          brk;
  logic          found;
  logic [LW-1:0] lane;

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    held_d  = held_q;
    press_d = '0;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    hc_d    = hc_q;
    mc_d    = mc_q;
    is_code = 1'b0;
    found   = 1'b0;
    lane    = '0;
    ext     = (state_q == EXT) || (state_q == EXT_BRK);
    brk     = (state_q == BRK) || (state_q == EXT_BRK);

    if (ps2.received_data_en) begin
      to_d = '0;
      unique case (1'b1)
        ps2.received_data == 8'hE0: state_d = EXT;
        ps2.received_data == 8'hF0:
          state_d = ext ? EXT_BRK : BRK;
        default: begin
          is_code = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      // a lost byte must not leave a stale prefix forever
      if (to_q == TO_MAX) begin
        state_d = IDLE;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end

    for (int k = 0; k < NUM_LANES; k++) begin
      if (!found &&
          ps2.received_data == LANE_CODES[8*k +: 8] &&
          (ext || !REQUIRE_EXT)) begin
        found = 1'b1;
        lane  = LW'(k);
      end
    end

    if (!check_input) begin
      held_d = '0;
    end else if (is_code && found) begin
      if (brk) begin
        held_d[lane] = 1'b0;
      end else if (!held_q[lane]) begin
        held_d[lane]  = 1'b1;
        press_d[lane] = 1'b1;
        if (tile_valid && 32'(tile_column) == 32'(lane))
          hit_d = 1'b1;
        else
          miss_d = 1'b1;
      end
    end

    if (counts_clear)
      hc_d = '0;
    else if (hit_d && hc_q != '1)
      hc_d = hc_q + 1'b1;

    if (counts_clear)
      mc_d = '0;
    else if (miss_d && mc_q != '1)
      mc_d = mc_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      to_q    <= '0;
      held_q  <= '0;
      press_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      hc_q    <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      held_q  <= held_d;
      press_q <= press_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      hc_q    <= hc_d;
      mc_q    <= mc_d;
    end
  end

  assign key_held     = held_q;
  assign key_press    = press_q;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign hit_count    = hc_q;
  assign miss_count   = mc_q;
  assign parser_state = state_q;

endmodule

// File: tb/tb_ps2_lane_key_decoder.sv
// Directed bench for ps2_lane_key_decoder: vector table plus
// hand sequences for timeout, saturation, enable and reset.
module tb_ps2_lane_key_decoder;

  localparam int TO = 16;

  logic       clock;
  logic       resetn;
  logic       check_input;
  logic       tile_valid;
  logic [2:0] tile_column;
  logic       counts_clear;
  logic [3:0] key_held;
  logic [3:0] key_press;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] hit_count;
  logic [7:0] miss_count;
  logic [1:0] parser_state;

  ps2_lane_key_decoder_if ps2 ();

  ps2_lane_key_decoder #(
    .PREFIX_TIMEOUT(TO)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .check_input  (check_input),
    .ps2          (ps2.slave),
    .tile_valid   (tile_valid),
    .tile_column  (tile_column),
    .counts_clear (counts_clear),
    .key_held     (key_held),
    .key_press    (key_press),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .parser_state (parser_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [7:0] b;
    logic       tv;
    logic [2:0] col;
    logic [3:0] held;
    logic [3:0] press;
    logic       hit;
    logic       miss;
    logic [7:0] hc;
    logic [7:0] mc;
    logic [1:0] st;
  } vec_t;

  vec_t vq[$];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " held"},  32'(key_held),     32'(v.held));
    chk({tag, " press"}, 32'(key_press),    32'(v.press));
    chk({tag, " hit"},   32'(hit_pulse),    32'(v.hit));
    chk({tag, " miss"},  32'(miss_pulse),   32'(v.miss));
    chk({tag, " hcnt"},  32'(hit_count),    32'(v.hc));
    chk({tag, " mcnt"},  32'(miss_count),   32'(v.mc));
    chk({tag, " state"}, 32'(parser_state), 32'(v.st));
  endtask

  task automatic add(input logic en, input logic [7:0] b,
                     input logic tv, input logic [2:0] col,
                     input logic [3:0] held, input logic [3:0] press,
                     input logic hit, input logic miss,
                     input logic [7:0] hc, input logic [7:0] mc,
                     input logic [1:0] st);
    vec_t v;
    v = '{en, b, tv, col, held, press, hit, miss, hc, mc, st};
    vq.push_back(v);
  endtask

  // strobe one byte; returns on the negedge after the sampling edge
  task automatic send(input logic [7:0] b);
    @(negedge clock);
    ps2.received_data    = b;
    ps2.received_data_en = 1'b1;
    @(negedge clock);
    ps2.received_data_en = 1'b0;
  endtask

  task automatic press_up;
    send(8'hE0);
    send(8'h75);
  endtask

  task automatic release_up;
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    resetn               = 1'b0;
    check_input          = 1'b1;
    tile_valid           = 1'b0;
    tile_column          = 3'd0;
    counts_clear         = 1'b0;
    ps2.received_data    = 8'h00;
    ps2.received_data_en = 1'b0;

    //  en  byte  tv col  held   press  h m hc mc st
    add(0, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    add(1, 8'hE0, 1, 2, 4'h0, 4'h0, 0, 0, 0, 0, 1);
    add(1, 8'h75, 1, 2, 4'h4, 4'h4, 1, 0, 1, 0, 0);
    add(0, 8'h00, 1, 2, 4'h4, 4'h0, 0, 0, 1, 0, 0);
    add(1, 8'hE0, 0, 3, 4'h4, 4'h0, 0, 0, 1, 0, 1);
    add(1, 8'h6B, 1, 3, 4'h5, 4'h1, 0, 1, 1, 1, 0);
    add(1, 8'hE0, 1, 1, 4'h5, 4'h0, 0, 0, 1, 1, 1);
    add(1, 8'h72, 1, 1, 4'h7, 4'h2, 1, 0, 2, 1, 0);
    add(1, 8'hE0, 1, 1, 4'h7, 4'h0, 0, 0, 2, 1, 1);
    add(1, 8'h72, 1, 1, 4'h7, 4'h0, 0, 0, 2, 1, 0);
    add(1, 8'hE0, 1, 1, 4'h7, 4'h0, 0, 0, 2, 1, 1);
    add(1, 8'h72, 1, 1, 4'h7, 4'h0, 0, 0, 2, 1, 0);
    add(1, 8'hE0, 1, 1, 4'h7, 4'h0, 0, 0, 2, 1, 1);
    add(1, 8'hF0, 1, 1, 4'h7, 4'h0, 0, 0, 2, 1, 3);
    add(1, 8'h72, 1, 1, 4'h5, 4'h0, 0, 0, 2, 1, 0);
    add(1, 8'h74, 1, 3, 4'h5, 4'h0, 0, 0, 2, 1, 0);
    add(1, 8'hF0, 1, 3, 4'h5, 4'h0, 0, 0, 2, 1, 2);
    add(1, 8'hF0, 1, 3, 4'h5, 4'h0, 0, 0, 2, 1, 2);
    add(1, 8'hE0, 1, 0, 4'h5, 4'h0, 0, 0, 2, 1, 1);
    add(1, 8'h74, 1, 0, 4'hD, 4'h8, 0, 1, 2, 2, 0);
    add(1, 8'hAA, 1, 3, 4'hD, 4'h0, 0, 0, 2, 2, 0);
    add(1, 8'hE0, 1, 3, 4'hD, 4'h0, 0, 0, 2, 2, 1);
    add(1, 8'hFA, 1, 3, 4'hD, 4'h0, 0, 0, 2, 2, 0);
    add(1, 8'hE0, 1, 3, 4'hD, 4'h0, 0, 0, 2, 2, 1);
    add(1, 8'hF0, 1, 3, 4'hD, 4'h0, 0, 0, 2, 2, 3);
    add(1, 8'h74, 1, 3, 4'h5, 4'h0, 0, 0, 2, 2, 0);

    repeat (3) @(negedge clock);
    resetn = 1'b1;

    foreach (vq[i]) begin
      @(negedge clock);
      ps2.received_data    = vq[i].b;
      ps2.received_data_en = vq[i].en;
      tile_valid           = vq[i].tv;
      tile_column          = vq[i].col;
      @(negedge clock);
      ps2.received_data_en = 1'b0;
      chk_all($sformatf("vec%0d", i), vq[i]);
    end

    // prefix timeout: EXT persists TO edges, then IDLE
    send(8'hE0);
    chk("to_enter", 32'(parser_state), 32'd1);
    repeat (TO - 1) @(negedge clock);
    chk("to_hold", 32'(parser_state), 32'd1);
    @(negedge clock);
    chk("to_idle", 32'(parser_state), 32'd0);

    // release lane2, clear counts, then drive hit count to saturation
    release_up();
    chk("rel2_held", 32'(key_held), 32'h1);
    @(negedge clock);
    counts_clear = 1'b1;
    @(negedge clock);
    counts_clear = 1'b0;
    chk("clr_hc", 32'(hit_count), 32'd0);
    chk("clr_mc", 32'(miss_count), 32'd0);
    tile_valid  = 1'b1;
    tile_column = 3'd2;
    for (int i = 0; i < 255; i++) begin
      press_up();
      release_up();
    end
    chk("sat_255", 32'(hit_count), 32'd255);
    press_up();
    chk("sat_hit", 32'(hit_pulse), 32'd1);
    chk("sat_hold", 32'(hit_count), 32'd255);
    release_up();

    // hit and clear in the same cycle: pulse fires, count goes to 0
    send(8'hE0);
    @(negedge clock);
    ps2.received_data    = 8'h75;
    ps2.received_data_en = 1'b1;
    counts_clear         = 1'b1;
    @(negedge clock);
    ps2.received_data_en = 1'b0;
    counts_clear         = 1'b0;
    chk("clr_hit_pulse", 32'(hit_pulse), 32'd1);
    chk("clr_hit_cnt", 32'(hit_count), 32'd0);
    chk("clr_hit_press", 32'(key_press), 32'h4);

    // dropping check_input clears held bits and gags pulses
    @(negedge clock);
    check_input = 1'b0;
    @(negedge clock);
    chk("ci_held", 32'(key_held), 32'h0);
    send(8'hE0);
    send(8'h72);
    chk("ci_press", 32'(key_press), 32'h0);
    chk("ci_hit", 32'({hit_pulse, miss_pulse}), 32'h0);
    chk("ci_held2", 32'(key_held), 32'h0);
    chk("ci_hc", 32'(hit_count), 32'd0);
    chk("ci_mc", 32'(miss_count), 32'd0);
    send(8'hE0);
    check_input = 1'b1;
    send(8'h72);
    chk("ci_resume_press", 32'(key_press), 32'h2);
    chk("ci_resume_miss", 32'(miss_count), 32'd1);

    // async reset in the middle of E0,F0
    send(8'hE0);
    send(8'hF0);
    chk("pre_rst_state", 32'(parser_state), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_held", 32'(key_held), 32'h0);
    chk("rst_state", 32'(parser_state), 32'd0);
    chk("rst_cnts", 32'({hit_count, miss_count}), 32'h0);
    chk("rst_pulses",
        32'({key_press, hit_pulse, miss_pulse}), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
